// File: rtl/wb_b3_cmd_master.sv
// Wishbone B3 classic single-transfer master: one command in, one bus cycle, one response out.
// Define WB_MASTER_RETRY_EN to re-issue cycles terminated by rty (up to RETRY_LIMIT times).
module wb_b3_cmd_master #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned SELECT_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned RETRY_LIMIT    = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_address,
    input  logic [SELECT_WIDTH-1:0] cmd_select,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_status,
    output logic                    wb_cycle,
    output logic                    wb_strobe,
    output logic                    wb_writeEnable,
    output logic [ADDR_WIDTH-1:0]   wb_address,
    output logic [SELECT_WIDTH-1:0] wb_select,
    output logic [DATA_WIDTH-1:0]   wb_dataMaster,
    input  logic [DATA_WIDTH-1:0]   wb_dataSlave,
    input  logic                    wb_ack,
    input  logic                    wb_err,
    input  logic                    wb_rty
);

    localparam logic [1:0] StatusOk      = 2'd0;
    localparam logic [1:0] StatusErr     = 2'd1;
    localparam logic [1:0] StatusRty     = 2'd2;
    localparam logic [1:0] StatusTimeout = 2'd3;

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef WB_MASTER_RETRY_EN
    typedef enum logic [1:0] {StIdle, StBus, StResp, StBackoff} state_e;

    localparam int unsigned RT_W = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
    localparam logic [RT_W-1:0] RT_MAX = RT_W'(RETRY_LIMIT);

    logic [RT_W-1:0] retry_cnt_q;
`else
    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    // Retry limit has no effect without the retry feature.
    logic unused_retry_limit;
    assign unused_retry_limit = ^RETRY_LIMIT;
`endif

    state_e              state_q;
    logic [TO_W-1:0]     to_cnt_q;
    logic                timeout_hit;
    logic                term_hit;
    logic                retry_now;
    logic [1:0]          term_status;
    logic [DATA_WIDTH-1:0] term_data;

    assign cmd_ready   = (state_q == StIdle);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST);

    // Termination decode for the BUS state, priority err > rty > ack > timeout.
    always_comb begin
        term_hit    = 1'b1;
        retry_now   = 1'b0;
        term_status = StatusOk;
        term_data   = '0;
        if (wb_err) begin
            term_status = StatusErr;
        end else if (wb_rty) begin
            term_status = StatusRty;
`ifdef WB_MASTER_RETRY_EN
            retry_now = (retry_cnt_q != RT_MAX);
            term_hit  = !retry_now;
`endif
        end else if (wb_ack) begin
            term_data = wb_dataSlave;
        end else if (timeout_hit) begin
            term_status = StatusTimeout;
        end else begin
            term_hit = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= StIdle;
            to_cnt_q       <= '0;
            wb_cycle       <= 1'b0;
            wb_strobe      <= 1'b0;
            wb_writeEnable <= 1'b0;
            wb_address     <= '0;
            wb_select      <= '0;
            wb_dataMaster  <= '0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_status     <= StatusOk;
`ifdef WB_MASTER_RETRY_EN
            retry_cnt_q    <= '0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        wb_cycle       <= 1'b1;
                        wb_strobe      <= 1'b1;
                        wb_writeEnable <= cmd_write;
                        wb_address     <= cmd_address;
                        wb_select      <= cmd_select;
                        wb_dataMaster  <= cmd_data;
                        to_cnt_q       <= '0;
`ifdef WB_MASTER_RETRY_EN
                        retry_cnt_q    <= '0;
`endif
                        state_q        <= StBus;
                    end
                end
                StBus: begin
                    if (term_hit) begin
                        wb_cycle   <= 1'b0;
                        wb_strobe  <= 1'b0;
                        rsp_valid  <= 1'b1;
                        rsp_data   <= term_data;
                        rsp_status <= term_status;
                        state_q    <= StResp;
                    end else if (retry_now) begin
`ifdef WB_MASTER_RETRY_EN
                        wb_cycle    <= 1'b0;
                        wb_strobe   <= 1'b0;
                        retry_cnt_q <= retry_cnt_q + 1'b1;
                        state_q     <= StBackoff;
`endif
                    end else if (to_cnt_q != '1) begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
`ifdef WB_MASTER_RETRY_EN
                StBackoff: begin
                    // Latched command is still on the wb_* outputs; just reopen the cycle.
                    wb_cycle  <= 1'b1;
                    wb_strobe <= 1'b1;
                    to_cnt_q  <= '0;
                    state_q   <= StBus;
                end
`endif
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_b3_cmd_master.sv
// Self-checking bench for wb_b3_cmd_master: vector table, random transactions vs a model,
// reset-mid-cycle and disabled-timeout sequences.
module tb_wb_b3_cmd_master;

    localparam int TO = 16;
    localparam int RL = 3;
`ifdef WB_MASTER_RETRY_EN
    localparam bit RetryEn = 1'b1;
`else
    localparam bit RetryEn = 1'b0;
`endif

    // Slave response kinds
    localparam int TNone = 0, TAck = 1, TErr = 2, TRty = 3, TErrAck = 4, TRtyAck = 5;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_address, cmd_data;
    logic [3:0]  cmd_select;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        wb_cycle, wb_strobe, wb_writeEnable;
    logic [31:0] wb_address, wb_dataMaster, wb_dataSlave;
    logic [3:0]  wb_select;
    logic        wb_ack, wb_err, wb_rty;

    logic        nt_cmd_valid, nt_cmd_ready, nt_rsp_valid;
    logic [31:0] nt_rsp_data, nt_wb_address, nt_wb_dataMaster;
    logic [1:0]  nt_rsp_status;
    logic        nt_wb_cycle, nt_wb_strobe, nt_wb_writeEnable;
    logic [3:0]  nt_wb_select;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    wb_b3_cmd_master #(.TIMEOUT_CYCLES(TO), .RETRY_LIMIT(RL)) u_dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_select(cmd_select), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_status(rsp_status),
        .wb_cycle(wb_cycle), .wb_strobe(wb_strobe), .wb_writeEnable(wb_writeEnable),
        .wb_address(wb_address), .wb_select(wb_select), .wb_dataMaster(wb_dataMaster),
        .wb_dataSlave(wb_dataSlave), .wb_ack(wb_ack), .wb_err(wb_err), .wb_rty(wb_rty)
    );

    // Same master with the timeout disabled and a silent slave.
    wb_b3_cmd_master #(.TIMEOUT_CYCLES(0), .RETRY_LIMIT(RL)) u_dut_nt (
        .clock(clock), .reset(reset),
        .cmd_valid(nt_cmd_valid), .cmd_ready(nt_cmd_ready), .cmd_write(cmd_write),
        .cmd_address(cmd_address), .cmd_select(cmd_select), .cmd_data(cmd_data),
        .rsp_valid(nt_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(nt_rsp_data),
        .rsp_status(nt_rsp_status),
        .wb_cycle(nt_wb_cycle), .wb_strobe(nt_wb_strobe), .wb_writeEnable(nt_wb_writeEnable),
        .wb_address(nt_wb_address), .wb_select(nt_wb_select),
        .wb_dataMaster(nt_wb_dataMaster),
        .wb_dataSlave(zero_word), .wb_ack(zero_bit), .wb_err(zero_bit), .wb_rty(zero_bit)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
        int          wait_n;
        int          term;
        int          n_rty;
        logic [31:0] rdata;
        int          hold;
        int          st;
        logic [31:0] d;
        int          cyc;
        int          ph;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: walk bus phases; each phase either times out or ends after wait_n+1 cycles.
    function automatic void model(input int wait_n, input int term, input int n_rty,
                                  input logic [31:0] rdata, output int st,
                                  output logic [31:0] d, output int cyc, output int ph);
        int t;
        st = 0; d = '0; cyc = 0; ph = 0;
        for (int p = 0; p <= RL + 1; p++) begin
            ph++;
            t = (p < n_rty) ? TRty : term;
            if (t == TNone || wait_n >= TO) begin
                st = 3; cyc += TO; return;
            end
            cyc += wait_n + 1;
            if (t == TErr || t == TErrAck) begin
                st = 1; return;
            end
            if (t == TAck) begin
                st = 0; d = rdata; return;
            end
            if (!RetryEn || p == RL) begin
                st = 2; return;
            end
        end
    endfunction

    task automatic drive_term(input int t, input logic [31:0] rdata);
        wb_ack       = (t == TAck) || (t == TErrAck) || (t == TRtyAck);
        wb_err       = (t == TErr) || (t == TErrAck);
        wb_rty       = (t == TRty) || (t == TRtyAck);
        wb_dataSlave = (t == TNone) ? ~rdata : rdata;
    endtask

    task automatic run_txn(input string name, input vec_t v);
        int  cyc, ph, lat, k;
        bit  prev, got;
        @(negedge clock);
        chk({name, ".ready_idle"}, cmd_ready, 1'b1);
        cmd_write = v.wr; cmd_address = v.addr; cmd_select = v.sel; cmd_data = v.data;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        chk({name, ".bus_fields"},
            {cmd_ready, wb_cycle, wb_strobe, wb_writeEnable, wb_address, wb_select, wb_dataMaster},
            {1'b0, 1'b1, 1'b1, v.wr, v.addr, v.sel, v.data});
        cyc = 0; ph = 0; lat = 0; k = 0; prev = 1'b0; got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (wb_cycle) begin
                if (!prev) begin
                    ph++;
                    k = 0;
                end
                cyc++;
                drive_term((k == v.wait_n) ? ((ph - 1 < v.n_rty) ? TRty : v.term) : TNone,
                           v.rdata);
                k++;
            end else begin
                drive_term(TNone, v.rdata);
            end
            prev = wb_cycle;
            lat++;
            @(negedge clock);
        end
        drive_term(TNone, v.rdata);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s.no_response: got none within 400 cycles, expected rsp_valid", name);
            return;
        end
        chk({name, ".status"}, rsp_status, v.st);
        chk({name, ".data"}, rsp_data, v.d);
        chk({name, ".cycle_count"}, cyc, v.cyc);
        chk({name, ".phases"}, ph, v.ph);
        chk({name, ".latency"}, lat, v.cyc + v.ph - 1);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clock);
            chk({name, ".hold"}, {rsp_valid, rsp_status, rsp_data, cmd_ready, wb_cycle},
                {1'b1, 2'(v.st), v.d, 1'b0, 1'b0});
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        chk({name, ".handshake"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        vec_t rv;
        int   cnt;
        bit   bad;

        reset = 1'b1; cmd_valid = 1'b0; nt_cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_write = 1'b0; cmd_address = '0; cmd_select = '0; cmd_data = '0;
        drive_term(TNone, 32'h0);

        //             wr    addr        sel    data          w   term     nr rdata         hold
        //             st    d             cyc                 ph
        vecs[0]  = '{1'b1, 32'h1, 4'hF, 32'h000000F0, 0, TAck, 0, 32'h0, 0,
                     0, 32'h0, 1, 1};
        vecs[1]  = '{1'b0, 32'h0, 4'hF, 32'h0, 3, TAck, 0, 32'hDEADBEEF, 0,
                     0, 32'hDEADBEEF, 4, 1};
        vecs[2]  = '{1'b0, 32'h8, 4'hF, 32'h0, 1, TErrAck, 0, 32'h55, 0,
                     1, 32'h0, 2, 1};
        vecs[3]  = '{1'b0, 32'hC, 4'h1, 32'h0, 0, TNone, 0, 32'h77, 0,
                     3, 32'h0, TO, 1};
        vecs[4]  = '{1'b0, 32'h10, 4'hF, 32'h0, TO - 1, TAck, 0, 32'h1234, 0,
                     0, 32'h1234, TO, 1};
        vecs[5]  = '{1'b0, 32'h14, 4'hF, 32'h0, TO, TAck, 0, 32'h4321, 0,
                     3, 32'h0, TO, 1};
        vecs[6]  = '{1'b1, 32'h18, 4'hC, 32'hAA, 0, TRty, 0, 32'h9, 0,
                     2, 32'h0, RetryEn ? 4 : 1, RetryEn ? 4 : 1};
        vecs[7]  = '{1'b0, 32'h1C, 4'hF, 32'h0, 0, TAck, 3, 32'hCAFE, 0,
                     RetryEn ? 0 : 2, RetryEn ? 32'hCAFE : 32'h0,
                     RetryEn ? 4 : 1, RetryEn ? 4 : 1};
        vecs[8]  = '{1'b1, 32'h20, 4'h3, 32'h5A5A, 2, TAck, 0, 32'hA5A5, 5,
                     0, 32'hA5A5, 3, 1};
        vecs[9]  = '{1'b0, 32'h24, 4'hF, 32'h0, 1, TRtyAck, 0, 32'h66, 0,
                     2, 32'h0, RetryEn ? 8 : 2, RetryEn ? 4 : 1};
        vecs[10] = '{1'b0, 32'h28, 4'hF, 32'h0, 0, TAck, 4, 32'hBEEF, 1,
                     2, 32'h0, RetryEn ? 4 : 1, RetryEn ? 4 : 1};

        repeat (2) @(negedge clock);
        chk("reset_outputs",
            {wb_cycle, wb_strobe, wb_writeEnable, wb_address, wb_select, wb_dataMaster,
             rsp_valid, rsp_status, rsp_data}, '0);
        reset = 1'b0;
        @(negedge clock);
        chk("reset_cmd_ready", cmd_ready, 1'b1);

        for (int i = 0; i < 11; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        for (int i = 0; i < 40; i++) begin
            rv.wr     = 1'($urandom_range(0, 1));
            rv.addr   = $urandom;
            rv.sel    = 4'($urandom_range(0, 15));
            rv.data   = $urandom;
            rv.wait_n = $urandom_range(0, 20);
            rv.term   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 5) : TAck;
            rv.n_rty  = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
            rv.rdata  = $urandom;
            rv.hold   = $urandom_range(0, 3);
            model(rv.wait_n, rv.term, rv.n_rty, rv.rdata, rv.st, rv.d, rv.cyc, rv.ph);
            run_txn($sformatf("rand%0d", i), rv);
        end

        // Reset in the middle of a bus cycle: cycle drops at the reset edge, no response.
        @(negedge clock);
        cmd_write = 1'b1; cmd_address = 32'h40; cmd_select = 4'hF; cmd_data = 32'h99;
        cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        chk("midreset.cycle_up", wb_cycle, 1'b1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        chk("midreset.at_edge", {wb_cycle, wb_strobe, rsp_valid, cmd_ready}, 4'b0001);
        @(negedge clock);
        reset = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (rsp_valid || wb_cycle) bad = 1'b1;
        end
        chk("midreset.no_response", bad, 1'b0);

        // Disabled timeout: the cycle stays open indefinitely.
        cmd_write = 1'b1; cmd_address = 32'h80; cmd_select = 4'h5; cmd_data = 32'h1357;
        nt_cmd_valid = 1'b1;
        @(negedge clock);
        nt_cmd_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 120; i++) begin
            if (nt_wb_cycle && !nt_rsp_valid) cnt++;
            @(negedge clock);
        end
        chk("no_timeout.cycles_high", cnt, 120);
        chk("no_timeout.outputs",
            {nt_cmd_ready, nt_rsp_valid, nt_wb_strobe, nt_wb_writeEnable, nt_wb_address,
             nt_wb_select, nt_wb_dataMaster, nt_rsp_status, nt_rsp_data},
            {1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 4'h5, 32'h1357, 2'b00, 32'h0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/wb_b3_cmd_master.md
Name: wb_b3_cmd_master

Overview:
- Wishbone B3 classic single-transfer bus master that sits directly upstream of the register-style Wishbone slaves (set/clear/toggle register blocks).
- Takes one command at a time on a valid/ready interface, runs one Wishbone cycle, and returns the read data and a completion status on a valid/ready response interface.
- Ends a hung cycle with a timeout.
- Bus ports map one-to-one onto wishbone_b3 fields: cycle, strobe, writeEnable, address, select, dataMaster, dataSlave, ack, err, rty.

Parameters:
- DATA_WIDTH, 32, width of the data buses
- SELECT_WIDTH, 4, number of byte-select lanes
- ADDR_WIDTH, 32, width of the address bus
- TIMEOUT_CYCLES, 16, number of bus-active cycles before the master aborts; 0 disables the timeout
- RETRY_LIMIT, 3, maximum re-issues after rty; used only when WB_MASTER_RETRY_EN is defined

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDR_WIDTH  target address
- cmd_select  in  SELECT_WIDTH  byte selects
- cmd_data  in  DATA_WIDTH  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes the response
- rsp_data  out  DATA_WIDTH  dataSlave captured on ack
- rsp_status  out  2  0 OK, 1 ERR, 2 RTY/retry-exhausted, 3 TIMEOUT
- wb_cycle  out  1  Wishbone cycle
- wb_strobe  out  1  Wishbone strobe
- wb_writeEnable  out  1  Wishbone write enable
- wb_address  out  ADDR_WIDTH  Wishbone address
- wb_select  out  SELECT_WIDTH  Wishbone byte selects
- wb_dataMaster  out  DATA_WIDTH  Wishbone write data
- wb_dataSlave  in  DATA_WIDTH  Wishbone read data
- wb_ack  in  1  Wishbone acknowledge
- wb_err  in  1  Wishbone error
- wb_rty  in  1  Wishbone retry

Behaviour:
- Reset: synchronous and active-high. All outputs are registered and go to 0 at the reset edge, except cmd_ready. State goes to IDLE, counters clear. cmd_ready is combinational (state==IDLE), so it reads 1 once reset deasserts.
- Reset mid-cycle: wb_cycle and wb_strobe drop at the reset edge. The pending command is discarded and no response is produced.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: latch the command onto the wb_* outputs, set wb_cycle=wb_strobe=1, clear the timeout counter, go to BUS.
- State BUS:
  - cmd_ready=0.
  - At each posedge, sample the terminations with priority err > rty > ack.
  - ack: rsp_data<=wb_dataSlave, status 0.
  - err: rsp_data<=0, status 1.
  - rty: status 2 (non-retry build).
  - On any termination: wb_cycle=wb_strobe=0, rsp_valid=1, go to RESP.
  - No termination: increment the timeout counter. When it reaches TIMEOUT_CYCLES-1, abort with status 3 and rsp_data=0, so wb_cycle is high for exactly TIMEOUT_CYCLES cycles.
  - The timeout counter is clog2(TIMEOUT_CYCLES+1) bits and saturates; it never wraps.
- State RESP:
  - rsp_valid=1. rsp_data and rsp_status stay stable until rsp_ready.
  - On rsp_valid&rsp_ready: clear rsp_valid, go to IDLE.
  - A new command is accepted no earlier than the cycle after the response handshake.
- Latency: command accepted at edge N; wb_cycle high during cycle N..N+1; a combinational ack is sampled at edge N+1; rsp_valid is high from edge N+1. Minimum 3 cycles per transaction (accept, bus, response).
- Terminations outside BUS are ignored.
- wb_* address, data, select and writeEnable hold their value after cycle drops; the slave must qualify them with cycle&strobe.

Optional Feature:
- Macro: WB_MASTER_RETRY_EN.
- Defined:
  - rty in BUS goes to state BACKOFF: wb_cycle=wb_strobe=0 for exactly one cycle, then re-enter BUS with the same latched command.
  - The timeout counter resets on each reissue.
  - A retry counter of clog2(RETRY_LIMIT+1) bits increments per rty.
  - An rty with retry count == RETRY_LIMIT ends the command with status 2.
  - The retry counter clears on every command accept.
- Undefined: no BACKOFF state and no retry counter; rty ends the command immediately with status 2.

Test Plan:
- Write cmd_address=0x1, cmd_data=0x000000F0, cmd_select=0xF; slave acks in its first cycle -> exactly one wb_cycle cycle with wb_writeEnable=1; rsp_status=0 at edge N+1.
- Read cmd_address=0x0; slave returns 0xDEADBEEF with ack after 3 wait cycles -> wb_cycle high 4 cycles; rsp_data=0xDEADBEEF, rsp_status=0.
- Slave asserts err and ack together -> rsp_status=1, rsp_data=0.
- Slave never responds, TIMEOUT_CYCLES=16 -> wb_cycle high exactly 16 cycles; rsp_status=3. With TIMEOUT_CYCLES=0 the cycle stays high 100+ cycles with no response.
- Slave answers rty three times then ack -> retry build: 4 bus phases separated by single-cycle cycle=0 gaps, status 0. Fourth rty with RETRY_LIMIT=3 -> status 2. Non-retry build: status 2 after the first rty.
- Assert reset during BUS -> wb_cycle=0 and rsp_valid=0 at the reset edge, no response; with rsp_ready held low 5 cycles, response data and status stay stable and cmd_ready stays 0.
